// File: rtl/othello_pkg.sv
// Shared constants, state encoding and command payload for the Othello board writer.
// Also provides a row-mask helper used when the flip mask is applied one row at a time.
package othello_pkg;

  localparam int unsigned NUM_SQ   = 64;
  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned ROW_LEN  = NUM_SQ / NUM_ROWS;
  localparam int unsigned SQ_W     = $clog2(NUM_SQ);
  localparam int unsigned ROW_W    = $clog2(NUM_ROWS);
  localparam int unsigned OP_W     = 2;

  localparam logic [OP_W-1:0] OP_MOVE = 2'b00;
  localparam logic [OP_W-1:0] OP_PASS = 2'b01;
  localparam logic [OP_W-1:0] OP_NEW  = 2'b10;
  localparam logic [OP_W-1:0] OP_RSV  = 2'b11;

  localparam logic [NUM_SQ-1:0] START_B_POS = 64'h0000_0008_1000_0000;
  localparam logic [NUM_SQ-1:0] START_R_POS = 64'h0000_0010_0800_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } fsmState;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              player;
    logic [SQ_W-1:0]   pos;
    logic [NUM_SQ-1:0] flip;
  } moveCmd;

  // All squares belonging to one board row.
  function automatic logic [NUM_SQ-1:0] rowMask(input logic [ROW_W-1:0] row);
    return NUM_SQ'({ROW_LEN{1'b1}}) << (32'(row) * ROW_LEN);
  endfunction

endpackage

// File: rtl/othello_move_check.sv
// Combinational legality check of a captured command against the current board and turn.
// Flags reserved ops, wrong-turn MOVE/PASS and malformed MOVE squares or flip masks.
module othello_move_check
  import othello_pkg::*;
(
  input  logic [NUM_SQ-1:0] B,
  input  logic [NUM_SQ-1:0] R,
  input  logic              turn,
  input  moveCmd            cmd,
  output logic              illegal_c
);

  logic [NUM_SQ-1:0] oppBoard;
  logic              isMove;
  logic              turnChecked;
  logic              occupied;
  logic              badFlip;

  always_comb begin
    oppBoard    = cmd.player ? B : R;
    isMove      = (cmd.op == OP_MOVE);
    turnChecked = (cmd.op == OP_MOVE) || (cmd.op == OP_PASS);
    occupied    = B[cmd.pos] | R[cmd.pos];
    // Flips must be non-empty, only hit opponent pieces, and never the placed square.
    badFlip     = (cmd.flip == '0) || ((cmd.flip & ~oppBoard) != '0) || cmd.flip[cmd.pos];
    illegal_c   = (cmd.op == OP_RSV)
                || (turnChecked && (cmd.player != turn))
                || (isMove && (occupied || badFlip));
  end

endmodule

// File: rtl/othello_board_writer.sv
// Authoritative Othello board: accepts MOVE/PASS/NEW_GAME, validates, places the piece,
// then flips one board row per cycle so the display sees a fixed update rate.
module othello_board_writer
  import othello_pkg::*;
#(
  parameter logic [NUM_SQ-1:0] START_B = START_B_POS,
  parameter logic [NUM_SQ-1:0] START_R = START_R_POS
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic              cmd_player,
  input  logic [SQ_W-1:0]   cmd_pos,
  input  logic [NUM_SQ-1:0] cmd_flip,
  output logic [NUM_SQ-1:0] B,
  output logic [NUM_SQ-1:0] R,
  output logic              turn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  fsmState            state, stateNext;
  moveCmd             cap, capNext;
  logic [ROW_W-1:0]   rowCnt, rowNext;
  logic [NUM_SQ-1:0]  bNext, rNext;
  logic [NUM_SQ-1:0]  posMask, rowFlip;
  logic               turnNext, doneNext, errNext, readyNext, busyNext;
  logic               illegal;

  othello_move_check u_check (
    .B         (B),
    .R         (R),
    .turn      (turn),
    .cmd       (cap),
    .illegal_c (illegal)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cap       <= '0;
      rowCnt    <= '0;
      B         <= START_B;
      R         <= START_R;
      turn      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      cap       <= capNext;
      rowCnt    <= rowNext;
      B         <= bNext;
      R         <= rNext;
      turn      <= turnNext;
      cmd_ready <= readyNext;
      busy      <= busyNext;
      done      <= doneNext;
      err       <= errNext;
    end
  end

  // Next-state, board update and registered status outputs.
  always_comb begin
    stateNext = state;
    capNext   = cap;
    rowNext   = rowCnt;
    bNext     = B;
    rNext     = R;
    turnNext  = turn;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    posMask   = NUM_SQ'(1) << cap.pos;
    rowFlip   = cap.flip & rowMask(rowCnt);

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          capNext   = '{op: cmd_op, player: cmd_player, pos: cmd_pos, flip: cmd_flip};
          stateNext = CHECK;
        end
      end
      CHECK: begin
        if (illegal) begin
          errNext   = 1'b1;
          doneNext  = 1'b1;
          stateNext = DONE;
        end else if (cap.op == OP_PASS) begin
          turnNext  = ~turn;
          doneNext  = 1'b1;
          stateNext = DONE;
        end else if (cap.op == OP_NEW) begin
          bNext     = START_B;
          rNext     = START_R;
          turnNext  = 1'b0;
          doneNext  = 1'b1;
          stateNext = DONE;
        end else begin
          if (cap.player) rNext = R | posMask;
          else            bNext = B | posMask;
          rowNext   = '0;
          stateNext = APPLY;
        end
      end
      APPLY: begin
        // Flip bits are a subset of the opponent board, so B & R stays zero.
        if (cap.player) begin
          rNext = R | rowFlip;
          bNext = B & ~rowFlip;
        end else begin
          bNext = B | rowFlip;
          rNext = R & ~rowFlip;
        end
        rowNext = rowCnt + ROW_W'(1);
        if (rowCnt == ROW_W'(NUM_ROWS - 1)) begin
          turnNext  = ~turn;
          doneNext  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    readyNext = (stateNext == IDLE);
    busyNext  = (stateNext != IDLE);
  end

endmodule

// File: doc/othello_board_writer.md
# othello_board_writer

Owns the authoritative Othello board state, the B and R 64-bit bitboards that the piece counter and the display logic read. It accepts move, pass and new-game commands from the game controller over a valid/ready handshake. Each move is checked for legality, the mover's piece is placed, and the flip mask is applied one board row per cycle, so the board changes at a fixed rate that the display can follow. It also tracks whose turn it is and reports completion and error status for every command.

## Interface
- START_B, default 64'h0000_0008_1000_0000: B bitboard loaded at reset and on NEW_GAME. Bits 28 and 35 are set.
- START_R, default 64'h0000_0010_0800_0000: R bitboard loaded at reset and on NEW_GAME. Bits 27 and 36 are set.
- clk, input, 1: the single clock. All state changes on the rising edge.
- RST, input, 1: asynchronous, active-high reset.
- cmd_valid, input, 1: a command is presented.
- cmd_ready, output, 1: the block can accept a command. High only in IDLE.
- cmd_op, input, 2: command code. 00 MOVE, 01 PASS, 10 NEW_GAME, 11 reserved (treated as illegal).
- cmd_player, input, 1: the mover. 0 is B, 1 is R.
- cmd_pos, input, 6: square index, row*8+col.
- cmd_flip, input, 64: squares to turn over to the mover.
- B, output, 64: black bitboard, registered.
- R, output, 64: red bitboard, registered.
- turn, output, 1: the player expected to move next.
- busy, output, 1: high whenever the block is not in IDLE.
- done, output, 1: one-cycle pulse when a command finishes.
- err, output, 1: high together with done when the command was rejected.

## Operation
- States: IDLE, CHECK, APPLY, DONE.
- IDLE: cmd_ready is high. When cmd_valid and cmd_ready are both high, the block captures op, player, pos and flip and moves to CHECK.
- CHECK takes one cycle. The command is illegal if any of these hold:
  - op is 11;
  - player is not equal to turn, for MOVE and PASS;
  - for MOVE, the square pos is already set in B or R;
  - for MOVE, flip is zero;
  - for MOVE, flip has any bit outside the opponent's board;
  - for MOVE, flip[pos] is set.
- CHECK outcomes:
  - Illegal: set the error flag and go to DONE. Boards and turn are unchanged.
  - PASS: toggle turn and go to DONE.
  - NEW_GAME: load B=START_B, R=START_R, turn=0, and go to DONE. NEW_GAME ignores cmd_player.
  - Legal MOVE: set bit pos on the mover's board, clear row counter r=0, and go to APPLY.
- APPLY takes 8 cycles. In row r, for every bit in flip[8r+7:8r], set that bit on the mover's board and clear it on the opponent's board. r increments each cycle. A row with zero flip bits still consumes its cycle. After r=7, toggle turn and go to DONE.
- DONE takes one cycle. done is high, err equals the error flag, and the error flag is cleared. The next state is IDLE.
- Invariant: (B & R) is zero at every clock edge.

## Timing
- Reset values: B=START_B, R=START_R, turn=0, state=IDLE, cmd_ready=1, busy=0, done=0, err=0.
- Take the accept edge as cycle 0. CHECK is cycle 1.
- Legal MOVE: the pos bit is visible on B/R after the cycle-1 edge. Row r is visible after edge 2+r. turn toggles and done pulses in cycle 10.
- Illegal command, PASS and NEW_GAME: done pulses in cycle 2. For PASS and NEW_GAME, the new turn and board values are visible in cycle 2.
- While busy, cmd_valid is ignored and not queued. The earliest next accept is the cycle after DONE.
- Reset asserted mid-APPLY: the board immediately returns to the start position with no partial flip retained, and done is not pulsed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- othello_pkg holds:
  - the op codes OP_MOVE, OP_PASS, OP_NEW, OP_RSV;
  - NUM_SQ=64 and NUM_ROWS=8;
  - the start-position constants;
  - the state encoding.
- Sub-module othello_move_check: purely combinational. Inputs are B, R, turn and the captured command. Output is a single illegal flag. The piece counter's bench reuses this sub-module.

## Test plan
- Reset, then MOVE player 0, pos 19, flip 64'h0000_0000_0800_0000. Required: B=64'h0000_0008_1808_0000, R=64'h0000_0010_0000_0000, turn=1, done in cycle 10, err=0.
- Reset, then MOVE player 0, pos 27. Required: done and err in cycle 2, B and R unchanged, turn=0.
- Reset, then MOVE player 1 (wrong turn). Required: err=1 and no state change. Then PASS player 0. Required: turn=1 and err=0 in cycle 2.
- MOVE with a flip bit on the mover's own square, and separately MOVE with flip=0. Required: both rejected.
- Legal move whose flip has bits in rows 3 and 4. Sample B every cycle. Required: row 3 changes after edge 5, row 4 changes after edge 6, and (B & R)=0 throughout.
- Assert RST at cycle 5 of an APPLY. Required: start position immediately, no done pulse. Then NEW_GAME after several moves. Required: start position restored and turn=0.
